// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC owner that sequences EX redirects, flush windows and FIFO parking.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined; otherwise the perf ports read 0.

package cpuPkg;
    localparam int PC_WIDTH = 16;
    typedef enum logic [2:0] {BR_NONE, BR_Z, BR_NZ, BR_N, BR_JMP, BR_FIFO} Branch;
endpackage

module fetch_sequencer
    import cpuPkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         FLUSH_DEPTH = 2,
    parameter int unsigned         CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_en,
    output logic                 flush,
    input  logic                 ex_valid,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  Branch                ex_branch_type,
    input  logic [PC_WIDTH-1:0]  bc_next_pc,
    input  logic                 stall_in,
    input  logic                 fifo_ready,
    output logic [CNT_WIDTH-1:0] perf_redirects,
    output logic [CNT_WIDTH-1:0] perf_fifo_cycles,
    output logic [CNT_WIDTH-1:0] perf_stall_cycles
);
    typedef enum logic [1:0] {RUN, REDIRECT, FIFO_WAIT} state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [PC_WIDTH-1:0] pc_n;
    logic                fifo_park, redirect;

    assign fifo_park = ex_valid && ex_branch_type == BR_FIFO && !fifo_ready;
    assign redirect  = ex_valid && ex_branch_type != BR_FIFO && bc_next_pc != ex_pc + PC_WIDTH'(1);

    // state, pc and flush-window counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end

    // next state and combinational fetch controls; reset forces both controls low
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        cnt_n    = cnt;
        flush    = 1'b0;
        fetch_en = 1'b0;
        case (state)
            RUN: begin
                if (fifo_park) begin
                    flush   = 1'b1;
                    pc_n    = ex_pc;
                    state_n = FIFO_WAIT;
                end else if (redirect) begin
                    flush    = 1'b1;
                    fetch_en = 1'b1;
                    pc_n     = bc_next_pc;
                    cnt_n    = 4'(FLUSH_DEPTH);
                    state_n  = REDIRECT;
                end else if (!stall_in) begin
                    fetch_en = 1'b1;
                    pc_n     = pc + PC_WIDTH'(1);
                end
            end
            REDIRECT: begin
                flush    = 1'b1;
                fetch_en = 1'b1;
                pc_n     = pc + PC_WIDTH'(1);
                cnt_n    = cnt - 4'd1;
                state_n  = cnt == 4'd1 ? RUN : REDIRECT;
            end
            FIFO_WAIT: begin
                flush = 1'b1;
                if (fifo_ready) begin
                    fetch_en = 1'b1;
                    pc_n     = pc + PC_WIDTH'(1);
                    cnt_n    = 4'(FLUSH_DEPTH);
                    state_n  = REDIRECT;
                end
            end
            default: state_n = RUN;
        endcase
        if (rst) begin
            flush    = 1'b0;
            fetch_en = 1'b0;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [CNT_WIDTH-1:0] red_q, fif_q, stl_q;

    // saturating perf counters, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            red_q <= '0;
            fif_q <= '0;
            stl_q <= '0;
        end else begin
            if (state == RUN && redirect && red_q != '1)
                red_q <= red_q + CNT_WIDTH'(1);
            if (state == FIFO_WAIT && fif_q != '1)
                fif_q <= fif_q + CNT_WIDTH'(1);
            if (state == RUN && !fifo_park && !redirect && stall_in && stl_q != '1)
                stl_q <= stl_q + CNT_WIDTH'(1);
        end
    end

    assign perf_redirects    = red_q;
    assign perf_fifo_cycles  = fif_q;
    assign perf_stall_cycles = stl_q;
`else
    assign perf_redirects    = {CNT_WIDTH{1'b0}};
    assign perf_fifo_cycles  = {CNT_WIDTH{1'b0}};
    assign perf_stall_cycles = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the fetch PC register and sequences redirects resolved by `branch_control` in EX. Compares `branch_control`'s `next_pc` against the sequential PC to detect taken branches, squashes younger instructions for a configurable bubble window, and parks fetch while a `BR_FIFO` instruction waits for FIFO data. Sits between EX-stage branch resolution, the hazard unit and the instruction memory. Imports `cpuPkg` for `PC_WIDTH` and `Branch`.

## Interface

**Parameters**
- `RESET_PC`, default 0: PC loaded on reset.
- `FLUSH_DEPTH`, default 2: number of REDIRECT cycles after the detection cycle; legal range 1..15.
- `CNT_WIDTH`, default 32: width of the perf counters.

**Ports**
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `pc` out `PC_WIDTH`: registered fetch PC to the instruction memory.
- `fetch_en` out 1: instruction memory read enable.
- `flush` out 1: invalidates all IF/ID contents at the next edge.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_pc` in `PC_WIDTH`: PC of the EX instruction; also drives `branch_control.pc`.
- `ex_branch_type` in `Branch`: branch type of the EX instruction.
- `bc_next_pc` in `PC_WIDTH`: `next_pc` from `branch_control`.
- `stall_in` in 1: load-use stall from the hazard unit.
- `fifo_ready` in 1: FIFO has data available.
- `perf_redirects` out `CNT_WIDTH`: perf counter, see Configuration.
- `perf_fifo_cycles` out `CNT_WIDTH`: perf counter, see Configuration.
- `perf_stall_cycles` out `CNT_WIDTH`: perf counter, see Configuration.

## Operation

**States.** RUN, REDIRECT (carries a down-counter `cnt`), FIFO_WAIT.

**Events.** These are evaluated in RUN only. `ex_valid` and `stall_in` are ignored in the other states.
- `fifo_park` = `ex_valid` & (`ex_branch_type`==`BR_FIFO`) & !`fifo_ready`.
- `redirect` = `ex_valid` & (`ex_branch_type`!=`BR_FIFO`) & (`bc_next_pc` != `ex_pc`+1). The addition is `PC_WIDTH`-bit and wraps.
- `BR_FIFO` with `fifo_ready`=1 is never a redirect. The instruction completes and fetch continues sequentially, overriding `branch_control`'s hold value.

**RUN** (priority order: `fifo_park`, then `redirect`, then `stall_in`)
- `fifo_park`: `flush`=1, `fetch_en`=0, `pc`<=`ex_pc`, go to FIFO_WAIT.
- `redirect`: `flush`=1, `fetch_en`=1, `pc`<=`bc_next_pc`, `cnt`<=`FLUSH_DEPTH`, go to REDIRECT.
- `stall_in`: `flush`=0, `fetch_en`=0, `pc` held.
- Otherwise: `flush`=0, `fetch_en`=1, `pc`<=`pc`+1 (wraps).

**REDIRECT**
- `flush`=1, `fetch_en`=1, `pc`<=`pc`+1, `cnt`<=`cnt`-1.
- When `cnt`==1, go to RUN.

**FIFO_WAIT**
- `flush`=1, `fetch_en`=0, `pc` held (equals the parked `ex_pc`).
- When `fifo_ready`=1: `fetch_en`=1, `pc`<=`pc`+1, `cnt`<=`FLUSH_DEPTH`, go to REDIRECT. The parked instruction is refetched at the held `pc`.

**Reset**
- While `rst`=1: `flush`=0 and `fetch_en`=0, forced combinationally.
- At the edge: `pc`<=`RESET_PC`, state<=RUN, `cnt`<=0.
- Reset in any state, including mid-FIFO_WAIT or mid-REDIRECT, behaves identically.

## Timing

- `pc` is registered. `flush` and `fetch_en` are combinational from state and inputs.
- A redirect detected in cycle t asserts `flush` for cycles t..t+`FLUSH_DEPTH`, i.e. 1+`FLUSH_DEPTH` cycles.
  - The target appears on `pc` in cycle t+1.
  - The first unflushed instruction is fetched at cycle t+1 and delivered once `flush` drops.
- A stall costs one cycle per asserted `stall_in` cycle. No latency is added otherwise.
- FIFO park: the earliest exit is one cycle after entry. `fifo_ready` sampled in the entry cycle is already accounted for by `fifo_park`.
- There is no back-to-back redirect from the flush window, because EX is invalid by construction and `ex_valid` is ignored.

## Configuration

- `FETCH_SEQ_PERF_EN` defined: three saturating counters, cleared by `rst`.
  - `perf_redirects` increments on each `redirect` event.
  - `perf_fifo_cycles` increments each cycle in FIFO_WAIT.
  - `perf_stall_cycles` increments each RUN cycle where `stall_in` takes effect.
- `FETCH_SEQ_PERF_EN` undefined: the ports still exist and are tied to 0, and no counter logic is generated.

## Test plan

- Reset with `RESET_PC`=0x0010, then release: `pc` = 0x0010, 0x0011, 0x0012 on successive cycles; `flush`=0; `fetch_en`=1.
- `FLUSH_DEPTH`=2; `ex_valid`=1, `BR_Z`, `ex_pc`=0x20, `bc_next_pc`=0x28:
  - `flush`=1 for 3 cycles.
  - `pc` = 0x28, 0x29, 0x2A, then RUN.
- Not-taken and wrap: `bc_next_pc`=`ex_pc`+1 gives no flush. With `ex_pc`=all-ones and `bc_next_pc`=0, there is no redirect and `pc` keeps incrementing.
- `BR_FIFO`, `ex_pc`=0x40, `fifo_ready`=0 for 5 cycles:
  - `fetch_en`=0, `flush`=1, `pc`=0x40 held.
  - Raising `fifo_ready` gives `fetch_en`=1 and `pc` → 0x41, 0x42; `flush` is high for 2 more cycles.
  - `perf_fifo_cycles`=6 with the macro defined.
- Simultaneous `stall_in`=1 and redirect to 0x80: the redirect wins, `pc`=0x80 next, and `perf_stall_cycles` does not increment. A stall alone for 3 cycles holds `pc` and gives `perf_stall_cycles`=3.
- Assert `rst` mid-FIFO_WAIT:
  - Next cycle: `pc`=`RESET_PC`, state RUN, counters 0.
  - Without the macro, all perf outputs stay 0 throughout.
